// File: rtl/multdiv_tracker.sv
// Scoreboard for the multi-cycle mul/div unit: tracks in-flight ops through a DEPTH-stage shift chain.
// Optional macro MULTDIV_WAW_CHECK_EN blocks issue to a destination register that is still pending.
`default_nettype none

module multdiv_tracker #(
  parameter int DEPTH = 17,
  parameter int REGW  = 5
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             issue_i,
  input  logic [REGW-1:0]  issue_rd_i,
  input  logic             issue_div_i,
  output logic             issue_ready_o,
  input  logic [REGW-1:0]  dx_rs_i,
  input  logic [REGW-1:0]  dx_rt_i,
  input  logic [REGW-1:0]  dx_rd_i,
  input  logic             dx_rd_rs_i,
  input  logic             dx_rd_rt_i,
  input  logic             dx_rd_rd_i,
  input  logic             wb_grant_i,
  output logic             wb_valid_o,
  output logic [REGW-1:0]  wb_rd_o,
  output logic [DEPTH-1:0] busy_stage_o,
  output logic [DEPTH-1:0] bp_reqX_o,
  output logic             exc_piped_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] div_q, div_d;
  logic [REGW-1:0]  rd_q [DEPTH];
  logic [REGW-1:0]  rd_d [DEPTH];

  logic freeze;
  logic accept;

  // A finished op that cannot get the writeback port stalls the entire chain.
  assign freeze = valid_q[DEPTH-1] & ~wb_grant_i;
  assign accept = issue_i & issue_ready_o;

`ifdef MULTDIV_WAW_CHECK_EN
  logic waw_hit;

  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == issue_rd_i) && (issue_rd_i != '0)) begin
        waw_hit = 1'b1;
      end
    end
  end

  assign issue_ready_o = ~freeze & ~waw_hit;
`else
  assign issue_ready_o = ~freeze;
`endif

  always_comb begin
    valid_d = valid_q;
    div_d   = div_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i] = rd_q[i];
    end
    if (!freeze) begin
      valid_d = {valid_q[DEPTH-2:0], accept};
      div_d   = {div_q[DEPTH-2:0], issue_div_i};
      rd_d[0] = issue_rd_i;
      for (int i = 1; i < DEPTH; i++) begin
        rd_d[i] = rd_q[i-1];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      div_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      div_q   <= div_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  assign wb_valid_o   = valid_q[DEPTH-1];
  assign wb_rd_o      = rd_q[DEPTH-1];
  assign busy_stage_o = valid_q;
  assign exc_piped_o  = |(valid_q & div_q);

  // Register 0 is hardwired, so a pending write to it never creates a hazard.
  always_comb begin
    bp_reqX_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bp_reqX_o[i] = valid_q[i] && (rd_q[i] != '0) &&
                     ((dx_rd_rs_i && (rd_q[i] == dx_rs_i)) ||
                      (dx_rd_rt_i && (rd_q[i] == dx_rt_i)) ||
                      (dx_rd_rd_i && (rd_q[i] == dx_rd_i)));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_tracker.sv
// Randomized bench for multdiv_tracker checked against a queue-of-ops reference model.
`default_nettype none

module tb_multdiv_tracker;

  localparam int DEPTH = 17;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue;
  logic [REGW-1:0]  issue_rd;
  logic             issue_div;
  logic             issue_ready;
  logic [REGW-1:0]  dx_rs, dx_rt, dx_rd;
  logic             dx_rd_rs, dx_rd_rt, dx_rd_rd;
  logic             wb_grant;
  logic             wb_valid;
  logic [REGW-1:0]  wb_rd;
  logic [DEPTH-1:0] busy_stage;
  logic [DEPTH-1:0] bp_reqX;
  logic             exc_piped;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [REGW-1:0] rd;
    logic            dv;
    int              stage;
  } op_t;

  op_t ops[$];

  always #5 clk = ~clk;

  multdiv_tracker #(.DEPTH(DEPTH), .REGW(REGW)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .issue_i      (issue),
    .issue_rd_i   (issue_rd),
    .issue_div_i  (issue_div),
    .issue_ready_o(issue_ready),
    .dx_rs_i      (dx_rs),
    .dx_rt_i      (dx_rt),
    .dx_rd_i      (dx_rd),
    .dx_rd_rs_i   (dx_rd_rs),
    .dx_rd_rt_i   (dx_rd_rt),
    .dx_rd_rd_i   (dx_rd_rd),
    .wb_grant_i   (wb_grant),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .busy_stage_o (busy_stage),
    .bp_reqX_o    (bp_reqX),
    .exc_piped_o  (exc_piped)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already applied; checks, then advances one clock.
  task automatic cycle();
    logic [DEPTH-1:0] e_busy, e_bp;
    logic             e_exc, e_wbv, e_frz, e_waw, e_rdy;
    logic [REGW-1:0]  e_wbrd;
    #1;
    e_busy = '0; e_bp = '0; e_exc = 1'b0; e_wbv = 1'b0; e_wbrd = '0; e_waw = 1'b0;
    foreach (ops[i]) begin
      e_busy[ops[i].stage] = 1'b1;
      if (ops[i].dv) e_exc = 1'b1;
      if (ops[i].stage == DEPTH-1) begin
        e_wbv  = 1'b1;
        e_wbrd = ops[i].rd;
      end
      if (ops[i].rd != 0 && ((dx_rd_rs && ops[i].rd == dx_rs) ||
                             (dx_rd_rt && ops[i].rd == dx_rt) ||
                             (dx_rd_rd && ops[i].rd == dx_rd)))
        e_bp[ops[i].stage] = 1'b1;
      if (ops[i].rd == issue_rd && issue_rd != 0) e_waw = 1'b1;
    end
    e_frz = e_wbv && !wb_grant;
`ifdef MULTDIV_WAW_CHECK_EN
    e_rdy = !e_frz && !e_waw;
`else
    e_rdy = !e_frz;
`endif
    check_val("busy_stage", 32'(busy_stage), 32'(e_busy));
    check_val("bp_reqX", 32'(bp_reqX), 32'(e_bp));
    check_val("exc_piped", 32'(exc_piped), 32'(e_exc));
    check_val("wb_valid", 32'(wb_valid), 32'(e_wbv));
    check_val("issue_ready", 32'(issue_ready), 32'(e_rdy));
    if (e_wbv) check_val("wb_rd", 32'(wb_rd), 32'(e_wbrd));
    @(posedge clk);
    if (reset) begin
      ops.delete();
    end else if (!e_frz) begin
      for (int i = ops.size() - 1; i >= 0; i--) begin
        op_t e;
        e = ops[i];
        e.stage = e.stage + 1;
        if (e.stage >= DEPTH) ops.delete(i);
        else ops[i] = e;
      end
      if (issue && e_rdy) begin
        op_t n;
        n.rd = issue_rd; n.dv = issue_div; n.stage = 0;
        ops.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; issue = 1'b0; issue_rd = '0; issue_div = 1'b0; wb_grant = 1'b1;
    dx_rs = '0; dx_rt = '0; dx_rd = '0; dx_rd_rs = 1'b0; dx_rd_rt = 1'b0; dx_rd_rd = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;
    cycle(); cycle();

    // single mul walking the chain to writeback
    issue = 1'b1; issue_rd = 5'd5; issue_div = 1'b0;
    cycle();
    issue = 1'b0;
    repeat (DEPTH + 2) cycle();

    // div with a matching DX source, then a zero-destination op
    issue = 1'b1; issue_rd = 5'd7; issue_div = 1'b1;
    cycle();
    issue = 1'b0; dx_rs = 5'd7; dx_rd_rs = 1'b1;
    repeat (5) cycle();
    issue = 1'b1; issue_rd = 5'd0; issue_div = 1'b1; dx_rs = 5'd0;
    cycle();
    issue = 1'b0;
    repeat (DEPTH + 2) cycle();
    idle_inputs();

    // writeback contention freezes the chain; blocked issue is not captured
    issue = 1'b1; issue_rd = 5'd3;
    cycle();
    issue = 1'b0;
    repeat (DEPTH - 1) cycle();
    wb_grant = 1'b0; issue = 1'b1; issue_rd = 5'd4;
    repeat (3) cycle();
    wb_grant = 1'b1; issue = 1'b0;
    repeat (DEPTH + 1) cycle();

    // back-to-back issue rd=1..20
    for (int k = 1; k <= 20; k++) begin
      issue = 1'b1; issue_rd = 5'(k); issue_div = k[0];
      cycle();
    end
    issue = 1'b0;
    repeat (DEPTH + 2) cycle();

    // same destination issued while the first is still pending
    issue = 1'b1; issue_rd = 5'd9; issue_div = 1'b0;
    cycle();
    repeat (4) cycle();
    issue = 1'b0;
    repeat (DEPTH + 5) cycle();

    // randomized traffic with contention and occasional resets
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      issue     = ($urandom_range(0, 2) != 0);
      issue_rd  = 5'($urandom_range(0, 7));
      issue_div = 1'($urandom);
      wb_grant  = ($urandom_range(0, 3) != 0);
      dx_rs     = 5'($urandom_range(0, 7));
      dx_rt     = 5'($urandom_range(0, 7));
      dx_rd     = 5'($urandom_range(0, 7));
      dx_rd_rs  = 1'($urandom);
      dx_rd_rt  = 1'($urandom);
      dx_rd_rd  = 1'($urandom);
      cycle();
    end
    idle_inputs();
    repeat (DEPTH + 2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
